// File: rtl/instruction_execute_if.sv
// Decode-to-execute handshake plus the EX/MEM latch outputs, bundled as one bus.
// master = decode side (drives ID_EX_*), slave = execute stage.
interface instruction_execute_if;
    logic [31:0] ID_EX_A;
    logic [31:0] ID_EX_B;
    logic [31:0] ID_EX_IMM;
    logic [31:0] ID_EX_NPC;
    logic [31:0] ID_EX_IR;
    logic        ID_EX_VALID;
    logic        EX_READY;
    logic [31:0] EX_MEM_ALUOUT;
    logic [31:0] EX_MEM_B;
    logic [31:0] EX_MEM_IR;
    logic [31:0] EX_MEM_NPC;
    logic        EX_MEM_COND;
    logic        EX_MEM_ILLEGAL;
    logic        EX_MEM_VALID;
    logic [31:0] PC_NEXT;

    modport master (
        output ID_EX_A, ID_EX_B, ID_EX_IMM, ID_EX_NPC, ID_EX_IR, ID_EX_VALID,
        input  EX_READY, EX_MEM_ALUOUT, EX_MEM_B, EX_MEM_IR, EX_MEM_NPC,
               EX_MEM_COND, EX_MEM_ILLEGAL, EX_MEM_VALID, PC_NEXT
    );

    modport slave (
        input  ID_EX_A, ID_EX_B, ID_EX_IMM, ID_EX_NPC, ID_EX_IR, ID_EX_VALID,
        output EX_READY, EX_MEM_ALUOUT, EX_MEM_B, EX_MEM_IR, EX_MEM_NPC,
               EX_MEM_COND, EX_MEM_ILLEGAL, EX_MEM_VALID, PC_NEXT
    );
endinterface

// File: rtl/instruction_execute.sv
// RV32I execute stage: ALU, branch/jump resolution and next-PC, registered
// into the EX/MEM latch. Shifts run one bit per cycle and stall decode.
// Optional macro SHIFT_FAST_EN: replaces the iterative shifter with a
// single-cycle barrel shifter (no SHIFT state, EX_READY tied high).
module instruction_execute #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    instruction_execute_if.slave bus
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    logic [XLEN-1:0] a, b, imm, npc, ir;
    logic [XLEN-1:0] op2, pc_cur, alu_d, target_d, pc_next_d, shift_res, sra_res;
    logic [6:0]      opcode, f7;
    logic [2:0]      f3;
    logic [4:0]      shamt;
    logic            cond_d, illegal_d, is_shift, sh_left, sh_arith, f7_ok;

    logic [XLEN-1:0] aluout_q, b_out_q, ir_out_q, npc_out_q, pc_next_q;
    logic            cond_q, illegal_q, valid_q;

    assign a   = bus.ID_EX_A;
    assign b   = bus.ID_EX_B;
    assign imm = bus.ID_EX_IMM;
    assign npc = bus.ID_EX_NPC;
    assign ir  = bus.ID_EX_IR;

    // Arithmetic shift kept in its own signal so the signed operand is not
    // turned unsigned by a surrounding mixed-sign expression.
    assign sra_res = $unsigned($signed(a) >>> shamt);

`ifdef SHIFT_FAST_EN
    assign shift_res = sh_left ? (a << shamt) : (sh_arith ? sra_res : (a >> shamt));
`else
    // Only used for shamt==0, which completes immediately with A unchanged.
    assign shift_res = a;
`endif

    // Decode and evaluate the instruction currently offered by decode.
    always_comb begin
        opcode    = ir[6:0];
        f3        = ir[14:12];
        f7        = ir[31:25];
        op2       = (opcode == OPC_OP) ? b : imm;
        pc_cur    = npc - 32'd4;
        shamt     = op2[4:0];
        alu_d     = '0;
        cond_d    = 1'b0;
        target_d  = npc;
        illegal_d = 1'b0;
        is_shift  = 1'b0;
        sh_left   = 1'b0;
        sh_arith  = 1'b0;
        f7_ok     = 1'b1;
        case (opcode)
            OPC_OP, OPC_OPIMM: begin
                // funct7 qualifies every register op, but only the shifts of OP-IMM
                if (opcode == OPC_OP)
                    f7_ok = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
                else if (f3 == 3'b001)
                    f7_ok = (f7 == 7'h00);
                else if (f3 == 3'b101)
                    f7_ok = (f7 == 7'h00) || (f7 == 7'h20);
                illegal_d = !f7_ok;
                case (f3)
                    3'b000:  alu_d = ((opcode == OPC_OP) && ir[30]) ? (a - op2) : (a + op2);
                    3'b001:  begin is_shift = 1'b1; sh_left = 1'b1; end
                    3'b010:  alu_d = {31'b0, ($signed(a) < $signed(op2))};
                    3'b011:  alu_d = {31'b0, (a < op2)};
                    3'b100:  alu_d = a ^ op2;
                    3'b101:  begin is_shift = 1'b1; sh_arith = ir[30]; end
                    3'b110:  alu_d = a | op2;
                    default: alu_d = a & op2;
                endcase
                if (is_shift)
                    alu_d = shift_res;
            end
            OPC_LOAD: begin
                alu_d     = a + imm;
                illegal_d = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_STORE: begin
                alu_d     = a + imm;
                illegal_d = (f3 > 3'b010);
            end
            OPC_LUI:   alu_d = imm;
            OPC_AUIPC: alu_d = pc_cur + imm;
            OPC_BRANCH: begin
                alu_d    = pc_cur + imm;
                target_d = pc_cur + imm;
                case (f3)
                    3'b000:  cond_d = (a == b);
                    3'b001:  cond_d = (a != b);
                    3'b100:  cond_d = ($signed(a) < $signed(b));
                    3'b101:  cond_d = ($signed(a) >= $signed(b));
                    3'b110:  cond_d = (a < b);
                    3'b111:  cond_d = (a >= b);
                    default: illegal_d = 1'b1;
                endcase
            end
            OPC_JAL: begin
                alu_d    = npc;
                cond_d   = 1'b1;
                target_d = pc_cur + imm;
            end
            OPC_JALR: begin
                alu_d     = npc;
                cond_d    = 1'b1;
                target_d  = (a + imm) & ~32'h1;
                illegal_d = (f3 != 3'b000);
            end
            default: illegal_d = 1'b1;
        endcase
        // An illegal encoding produces a clean, inert result
        if (illegal_d) begin
            alu_d    = '0;
            cond_d   = 1'b0;
            target_d = npc;
            is_shift = 1'b0;
        end
        pc_next_d = cond_d ? target_d : npc;
    end

`ifndef SHIFT_FAST_EN
    typedef enum logic {S_IDLE, S_SHIFT} state_t;
    state_t          state_q;
    logic [XLEN-1:0] work_q, ir_q, b_q, npc_q, work_step;
    logic [4:0]      cnt_q;
    logic            left_q, arith_q;

    assign work_step = left_q ? {work_q[30:0], 1'b0} : {arith_q & work_q[31], work_q[31:1]};
    assign bus.EX_READY = (state_q == S_IDLE);
`else
    assign bus.EX_READY = 1'b1;
`endif

    // EX/MEM latch plus the accept / iterative-shift state machine.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aluout_q  <= '0;
            b_out_q   <= '0;
            ir_out_q  <= '0;
            npc_out_q <= '0;
            cond_q    <= 1'b0;
            illegal_q <= 1'b0;
            valid_q   <= 1'b0;
            pc_next_q <= RESET_PC;
`ifndef SHIFT_FAST_EN
            state_q   <= S_IDLE;
            work_q    <= '0;
            cnt_q     <= '0;
            left_q    <= 1'b0;
            arith_q   <= 1'b0;
            ir_q      <= '0;
            b_q       <= '0;
            npc_q     <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
`ifdef SHIFT_FAST_EN
            if (bus.ID_EX_VALID) begin
                aluout_q  <= alu_d;
                b_out_q   <= b;
                ir_out_q  <= ir;
                npc_out_q <= npc;
                cond_q    <= cond_d;
                illegal_q <= illegal_d;
                pc_next_q <= pc_next_d;
                valid_q   <= 1'b1;
            end
`else
            case (state_q)
                S_IDLE: begin
                    if (bus.ID_EX_VALID) begin
                        if (is_shift && (shamt != 5'd0)) begin
                            // cnt_q counts shifts still to do; the last one retires the op
                            work_q  <= a;
                            cnt_q   <= shamt;
                            left_q  <= sh_left;
                            arith_q <= sh_arith;
                            ir_q    <= ir;
                            b_q     <= b;
                            npc_q   <= npc;
                            state_q <= S_SHIFT;
                        end else begin
                            aluout_q  <= alu_d;
                            b_out_q   <= b;
                            ir_out_q  <= ir;
                            npc_out_q <= npc;
                            cond_q    <= cond_d;
                            illegal_q <= illegal_d;
                            pc_next_q <= pc_next_d;
                            valid_q   <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    work_q <= work_step;
                    cnt_q  <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        aluout_q  <= work_step;
                        b_out_q   <= b_q;
                        ir_out_q  <= ir_q;
                        npc_out_q <= npc_q;
                        cond_q    <= 1'b0;
                        illegal_q <= 1'b0;
                        pc_next_q <= npc_q;
                        valid_q   <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
`endif
        end
    end

    assign bus.EX_MEM_ALUOUT  = aluout_q;
    assign bus.EX_MEM_B       = b_out_q;
    assign bus.EX_MEM_IR      = ir_out_q;
    assign bus.EX_MEM_NPC     = npc_out_q;
    assign bus.EX_MEM_COND    = cond_q;
    assign bus.EX_MEM_ILLEGAL = illegal_q;
    assign bus.EX_MEM_VALID   = valid_q;
    assign bus.PC_NEXT        = pc_next_q;
endmodule

// File: tb/tb_instruction_execute.sv
// Testbench for instruction_execute: directed vector table, hand-written
// multi-cycle sequences (back-to-back, reset mid-shift) and random
// instructions checked against a mnemonic-level reference model.
module tb_instruction_execute;
    localparam logic [31:0] RST_PC = 32'h0000_0ABC;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_txn = 0;

    instruction_execute_if bus();

    instruction_execute #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef enum {M_ADD, M_SUB, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_SRA, M_OR, M_AND,
                  M_LOAD, M_STORE, M_LUI, M_AUIPC, M_BEQ, M_BNE, M_BLT, M_BGE, M_BLTU,
                  M_BGEU, M_JAL, M_JALR, M_ILLEGAL} mnem_t;

    typedef struct {
        logic [31:0] ir, a, b, imm, npc;
        logic [31:0] alu;
        logic        cond, ill;
        logic [31:0] pc;
        int          lat;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic mnem_t alu_name(input logic [2:0] f3);
        case (f3)
            3'd0:    return M_ADD;
            3'd1:    return M_SLL;
            3'd2:    return M_SLT;
            3'd3:    return M_SLTU;
            3'd4:    return M_XOR;
            3'd5:    return M_SRL;
            3'd6:    return M_OR;
            default: return M_AND;
        endcase
    endfunction

    // RV32I decode table, instruction word -> mnemonic
    function automatic mnem_t decode(input logic [31:0] ir);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        opc = ir[6:0];
        f3  = ir[14:12];
        f7  = ir[31:25];
        case (opc)
            7'h33: begin
                if (f7 == 7'h00) return alu_name(f3);
                if (f7 == 7'h20 && f3 == 3'd0) return M_SUB;
                if (f7 == 7'h20 && f3 == 3'd5) return M_SRA;
                return M_ILLEGAL;
            end
            7'h13: begin
                if (f3 == 3'd1) begin
                    if (f7 == 7'h00) return M_SLL;
                    return M_ILLEGAL;
                end
                if (f3 == 3'd5) begin
                    if (f7 == 7'h00) return M_SRL;
                    if (f7 == 7'h20) return M_SRA;
                    return M_ILLEGAL;
                end
                return alu_name(f3);
            end
            7'h03: begin
                if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return M_ILLEGAL;
                return M_LOAD;
            end
            7'h23: begin
                if (f3 <= 3'd2) return M_STORE;
                return M_ILLEGAL;
            end
            7'h37: return M_LUI;
            7'h17: return M_AUIPC;
            7'h63: begin
                case (f3)
                    3'd0:    return M_BEQ;
                    3'd1:    return M_BNE;
                    3'd4:    return M_BLT;
                    3'd5:    return M_BGE;
                    3'd6:    return M_BLTU;
                    3'd7:    return M_BGEU;
                    default: return M_ILLEGAL;
                endcase
            end
            7'h6F: return M_JAL;
            7'h67: begin
                if (f3 == 3'd0) return M_JALR;
                return M_ILLEGAL;
            end
            default: return M_ILLEGAL;
        endcase
    endfunction

    // Architectural result of one instruction plus its expected latency in edges
    task automatic model(input logic [31:0] ir, a, b, imm, npc,
                         output logic [31:0] alu, output logic cond, output logic ill,
                         output logic [31:0] pc, output int lat);
        mnem_t       m;
        logic [31:0] o2, here, tgt;
        int          sh;
        m    = decode(ir);
        o2   = (ir[6:0] == 7'h33) ? b : imm;
        here = npc - 32'd4;
        tgt  = npc;
        sh   = int'(o2[4:0]);
        alu  = 32'd0;
        cond = 1'b0;
        ill  = 1'b0;
        lat  = 1;
        case (m)
            M_ADD:   alu = a + o2;
            M_SUB:   alu = a - o2;
            M_AND:   alu = a & o2;
            M_OR:    alu = a | o2;
            M_XOR:   alu = a ^ o2;
            M_SLT:   alu = ($signed(a) < $signed(o2)) ? 32'd1 : 32'd0;
            M_SLTU:  alu = (a < o2) ? 32'd1 : 32'd0;
            M_SLL:   begin alu = a << sh; lat = sh + 1; end
            M_SRL:   begin alu = a >> sh; lat = sh + 1; end
            M_SRA:   begin alu = $unsigned($signed(a) >>> sh); lat = sh + 1; end
            M_LOAD, M_STORE: alu = a + imm;
            M_LUI:   alu = imm;
            M_AUIPC: alu = here + imm;
            M_BEQ, M_BNE, M_BLT, M_BGE, M_BLTU, M_BGEU: begin
                alu = here + imm;
                tgt = here + imm;
                case (m)
                    M_BEQ:   cond = (a == b);
                    M_BNE:   cond = (a != b);
                    M_BLT:   cond = ($signed(a) < $signed(b));
                    M_BGE:   cond = ($signed(a) >= $signed(b));
                    M_BLTU:  cond = (a < b);
                    default: cond = (a >= b);
                endcase
            end
            M_JAL:   begin alu = npc; cond = 1'b1; tgt = here + imm; end
            M_JALR:  begin alu = npc; cond = 1'b1; tgt = (a + imm) & ~32'h1; end
            default: ill = 1'b1;
        endcase
`ifdef SHIFT_FAST_EN
        lat = 1;
`endif
        pc = cond ? tgt : npc;
    endtask

    // Offer one instruction, follow it to its VALID pulse, check everything
    task automatic run_instr(input logic [31:0] ir, a, b, imm, npc,
                             input logic [31:0] e_alu, input logic e_cond, input logic e_ill,
                             input logic [31:0] e_pc, input int e_lat);
        int edges;
        int rlow;
        @(negedge clk);
        bus.ID_EX_IR    = ir;
        bus.ID_EX_A     = a;
        bus.ID_EX_B     = b;
        bus.ID_EX_IMM   = imm;
        bus.ID_EX_NPC   = npc;
        bus.ID_EX_VALID = 1'b1;
        @(posedge clk); #1;
        edges = 1;
        rlow  = 0;
        // VALID stays high while stalled; it must be ignored during a shift
        while (!bus.EX_MEM_VALID && edges < 40) begin
            if (!bus.EX_READY) rlow++;
            @(posedge clk); #1;
            edges++;
        end
        bus.ID_EX_VALID = 1'b0;
        n_txn++;
        $display("txn %0d %s ir=%h a=%h b=%h imm=%h npc=%h -> alu=%h cond=%0b ill=%0b pc=%h edges=%0d",
                 n_txn, decode(ir).name(), ir, a, b, imm, npc, bus.EX_MEM_ALUOUT,
                 bus.EX_MEM_COND, bus.EX_MEM_ILLEGAL, bus.PC_NEXT, edges);
        check("latency", edges, e_lat);
        check("ready_low_cycles", rlow, e_lat - 1);
        check("aluout", bus.EX_MEM_ALUOUT, e_alu);
        check("cond", {31'b0, bus.EX_MEM_COND}, {31'b0, e_cond});
        check("illegal", {31'b0, bus.EX_MEM_ILLEGAL}, {31'b0, e_ill});
        check("pc_next", bus.PC_NEXT, e_pc);
        check("ir_pass", bus.EX_MEM_IR, ir);
        check("b_pass", bus.EX_MEM_B, b);
        check("npc_pass", bus.EX_MEM_NPC, npc);
        @(posedge clk); #1;
        check("valid_single_pulse", {31'b0, bus.EX_MEM_VALID}, 32'd0);
        check("aluout_held", bus.EX_MEM_ALUOUT, e_alu);
    endtask

    function automatic vec_t mk(input logic [31:0] ir, a, b, imm, npc, alu,
                                input logic cond, ill, input logic [31:0] pc, input int lat);
        vec_t v;
        v.ir = ir; v.a = a; v.b = b; v.imm = imm; v.npc = npc;
        v.alu = alu; v.cond = cond; v.ill = ill; v.pc = pc; v.lat = lat;
        return v;
    endfunction

    logic [6:0] opcs [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17,
                              7'h63, 7'h6F, 7'h67, 7'h0B, 7'h33};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ir, a, b, imm, npc, e_alu, e_pc, f7;
        logic        e_cond, e_ill;
        int          e_lat, seen;

        vecs[0]  = mk(32'h00000033, 32'd5, 32'd7, 32'd0, 32'h100, 32'd12, 1'b0, 1'b0, 32'h100, 1);
        vecs[1]  = mk(32'h40000033, 32'd5, 32'd7, 32'd0, 32'h100, 32'hFFFFFFFE, 1'b0, 1'b0, 32'h100, 1);
        vecs[2]  = mk(32'h40405013, 32'h80000000, 32'd0, 32'h404, 32'h108, 32'hF8000000, 1'b0, 1'b0, 32'h108, 5);
        vecs[3]  = mk(32'h00000063, 32'd3, 32'd3, 32'h10, 32'h104, 32'h110, 1'b1, 1'b0, 32'h110, 1);
        vecs[4]  = mk(32'h00000063, 32'd3, 32'd4, 32'h10, 32'h104, 32'h110, 1'b0, 1'b0, 32'h104, 1);
        vecs[5]  = mk(32'h0000006F, 32'd0, 32'd0, 32'h40, 32'h20, 32'h20, 1'b1, 1'b0, 32'h5C, 1);
        vecs[6]  = mk(32'h00002033, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h10, 32'd1, 1'b0, 1'b0, 32'h10, 1);
        vecs[7]  = mk(32'h00003033, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h14, 32'd0, 1'b0, 1'b0, 32'h14, 1);
        vecs[8]  = mk(32'h00000037, 32'h5555, 32'd0, 32'h12345000, 32'h18, 32'h12345000, 1'b0, 1'b0, 32'h18, 1);
        vecs[9]  = mk(32'h00000017, 32'd0, 32'd0, 32'h1000, 32'h204, 32'h1200, 1'b0, 1'b0, 32'h204, 1);
        vecs[10] = mk(32'h00000067, 32'h1001, 32'd0, 32'h10, 32'h44, 32'h44, 1'b1, 1'b0, 32'h1010, 1);
        vecs[11] = mk(32'h0000007F, 32'd9, 32'd9, 32'd9, 32'h300, 32'd0, 1'b0, 1'b1, 32'h300, 1);
        vecs[12] = mk(32'h00001033, 32'd1, 32'd31, 32'd0, 32'h400, 32'h80000000, 1'b0, 1'b0, 32'h400, 32);
        vecs[13] = mk(32'h00005013, 32'h1234, 32'd0, 32'd0, 32'h404, 32'h1234, 1'b0, 1'b0, 32'h404, 1);
        vecs[14] = mk(32'h02000033, 32'd5, 32'd7, 32'd0, 32'h408, 32'd0, 1'b0, 1'b1, 32'h408, 1);
        vecs[15] = mk(32'h00002023, 32'h100, 32'hDEAD, 32'hFFFFFFFC, 32'h40C, 32'hFC, 1'b0, 1'b0, 32'h40C, 1);
        vecs[16] = mk(32'h00006063, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFF0, 32'h10, 32'hFFFFFFFC, 1'b1, 1'b0, 32'hFFFFFFFC, 1);

        bus.ID_EX_IR = '0; bus.ID_EX_A = '0; bus.ID_EX_B = '0;
        bus.ID_EX_IMM = '0; bus.ID_EX_NPC = '0; bus.ID_EX_VALID = 1'b0;
        rst = 1'b1;
        #3 rst = 1'b0;
        #4;
        check("reset_aluout", bus.EX_MEM_ALUOUT, 32'd0);
        check("reset_valid", {31'b0, bus.EX_MEM_VALID}, 32'd0);
        check("reset_cond", {31'b0, bus.EX_MEM_COND}, 32'd0);
        check("reset_pc_next", bus.PC_NEXT, RST_PC);
        check("reset_ready", {31'b0, bus.EX_READY}, 32'd1);
        @(negedge clk);
        rst = 1'b1;

        // Directed vector table
        for (int i = 0; i < 17; i++) begin
            e_lat = vecs[i].lat;
`ifdef SHIFT_FAST_EN
            e_lat = 1;
`endif
            run_instr(vecs[i].ir, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].npc,
                      vecs[i].alu, vecs[i].cond, vecs[i].ill, vecs[i].pc, e_lat);
        end

        // Back-to-back non-shift instructions, one per cycle
        @(negedge clk);
        bus.ID_EX_IR = 32'h00000033; bus.ID_EX_A = 32'd1; bus.ID_EX_B = 32'd2;
        bus.ID_EX_IMM = 32'd0; bus.ID_EX_NPC = 32'h500; bus.ID_EX_VALID = 1'b1;
        @(posedge clk); #1;
        check("b2b_valid1", {31'b0, bus.EX_MEM_VALID}, 32'd1);
        check("b2b_alu1", bus.EX_MEM_ALUOUT, 32'd3);
        @(negedge clk);
        bus.ID_EX_IR = 32'h40000033; bus.ID_EX_A = 32'd10; bus.ID_EX_B = 32'd3;
        bus.ID_EX_NPC = 32'h504;
        @(posedge clk); #1;
        check("b2b_valid2", {31'b0, bus.EX_MEM_VALID}, 32'd1);
        check("b2b_alu2", bus.EX_MEM_ALUOUT, 32'd7);
        check("b2b_pc2", bus.PC_NEXT, 32'h504);
        bus.ID_EX_VALID = 1'b0;
        @(posedge clk); #1;
        check("b2b_valid_off", {31'b0, bus.EX_MEM_VALID}, 32'd0);
        $display("txn %0d back-to-back ADD,SUB -> alu=%h", ++n_txn, bus.EX_MEM_ALUOUT);

        // Reset in the middle of an SLLI by 10
        @(negedge clk);
        bus.ID_EX_IR = 32'h00A01013; bus.ID_EX_A = 32'd1; bus.ID_EX_B = 32'd0;
        bus.ID_EX_IMM = 32'd10; bus.ID_EX_NPC = 32'h600; bus.ID_EX_VALID = 1'b1;
        @(posedge clk); #1;
        bus.ID_EX_VALID = 1'b0;
`ifndef SHIFT_FAST_EN
        check("midshift_ready_low", {31'b0, bus.EX_READY}, 32'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_aluout", bus.EX_MEM_ALUOUT, 32'd0);
        check("rst_mid_ir", bus.EX_MEM_IR, 32'd0);
        check("rst_mid_npc", bus.EX_MEM_NPC, 32'd0);
        check("rst_mid_b", bus.EX_MEM_B, 32'd0);
        check("rst_mid_cond", {31'b0, bus.EX_MEM_COND}, 32'd0);
        check("rst_mid_valid", {31'b0, bus.EX_MEM_VALID}, 32'd0);
        check("rst_mid_pc_next", bus.PC_NEXT, RST_PC);
        check("rst_mid_ready", {31'b0, bus.EX_READY}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (bus.EX_MEM_VALID) seen++;
        end
        check("rst_mid_no_valid", seen, 0);
        check("rst_mid_pc_hold", bus.PC_NEXT, RST_PC);
        $display("txn %0d reset during SLLI -> pc_next=%h", ++n_txn, bus.PC_NEXT);
        run_instr(32'h00000033, 32'd20, 32'd22, 32'd0, 32'h700, 32'd42, 1'b0, 1'b0, 32'h700, 1);

        // Random instructions against the reference model
        for (int i = 0; i < 80; i++) begin
            ir = $urandom;
            ir[6:0] = opcs[$urandom_range(0, 10)];
            if (ir[6:0] == 7'h33 || ir[6:0] == 7'h13) begin
                case ($urandom_range(0, 3))
                    0, 1:    f7 = 32'h00;
                    2:       f7 = 32'h20;
                    default: f7 = $urandom;
                endcase
                ir[31:25] = f7[6:0];
            end
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            imm = $urandom;
            npc = {$urandom, 2'b00};
            model(ir, a, b, imm, npc, e_alu, e_cond, e_ill, e_pc, e_lat);
            run_instr(ir, a, b, imm, npc, e_alu, e_cond, e_ill, e_pc, e_lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
